// File: rtl/hazard_ctrl_if.sv
// ID-stage operand/destination info toward the hazard scheduler and its pipeline controls back.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  localparam int unsigned REG_W = 5;

  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic [REG_W-1:0] id_dest;
  logic             id_mem_r_en;
  logic             id_br_taken;
  logic             freeze;

  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             br_taken_out;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, id_br_taken, freeze,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, br_taken_out,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, id_br_taken, freeze,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, br_taken_out,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for a 5-stage MIPS pipeline: tracks destinations in EXE/MEM/WB,
// stalls/bubbles on RAW hazards, gates taken branches and counts stalls/flushes.
module hazard_ctrl #(
  parameter bit          FWD_EN    = 1'b1,
  parameter bit          WB_BYPASS = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic             v;
    logic             wb;
    logic             mr;
    logic [REG_W-1:0] dst;
  } sb_entry_t;

  sb_entry_t        e_q, m_q, w_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             raw_e, raw_m, raw_w, raw_hazard;
  logic             hazard, br_ok;

  function automatic logic src_match(input sb_entry_t x, input logic [REG_W-1:0] s);
    return x.v & x.wb & (x.dst == s) & (s != '0);
  endfunction

  // RAW detection of the ID instruction against each in-flight stage
  always_comb begin
    raw_e      = 1'b0;
    raw_m      = 1'b0;
    raw_w      = 1'b0;
    raw_hazard = 1'b0;
    if (bus.id_valid) begin
      raw_e = src_match(e_q, bus.id_src1) | (bus.id_two_src & src_match(e_q, bus.id_src2));
      raw_m = src_match(m_q, bus.id_src1) | (bus.id_two_src & src_match(m_q, bus.id_src2));
      raw_w = src_match(w_q, bus.id_src1) | (bus.id_two_src & src_match(w_q, bus.id_src2));
    end
    if (FWD_EN) raw_hazard = raw_e & e_q.mr;
    else        raw_hazard = raw_e | raw_m | (raw_w & ~WB_BYPASS);
  end

  // Freeze masks the stall; reset forces the pipeline to run with no bubble or branch
  assign hazard = raw_hazard & ~bus.freeze & ~rst;
  assign br_ok  = bus.id_br_taken & bus.id_valid & ~hazard & ~bus.freeze & ~rst;

  assign bus.pc_write_en   = rst | (~hazard & ~bus.freeze);
  assign bus.ifid_write_en = rst | (~hazard & ~bus.freeze);
  assign bus.idex_bubble   = hazard;
  assign bus.br_taken_out  = br_ok;
  assign bus.ifid_flush    = br_ok;
  assign bus.stall_count   = stall_q;
  assign bus.flush_count   = flush_q;

  // Scoreboard advance and saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else if (!bus.freeze) begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= hazard ? '0 : {bus.id_valid, bus.id_wb_en, bus.id_mem_r_en, bus.id_dest};
      if (hazard && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (br_ok && (flush_q != '1))  flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Not every scoreboard field or stage match is consumed in every configuration
  logic unused;
  assign unused = ^{w_q.mr, raw_m, raw_w};
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard scheduler for the 5-stage MIPS pipeline (IF, ID, EXE, MEM, WB).
- Keeps a 3-entry scoreboard of in-flight destination registers for the instructions in EXE, MEM and WB.
- Compares the instruction in ID against that scoreboard and drives stall, bubble and flush controls to the PC, IF/ID and ID/EX registers.
- Also gates branches and keeps saturating performance counters.

Parameters:
- FWD_EN, 1: 1 = forwarding unit present, so only a load in EXE causes a stall; 0 = stall on any RAW match.
- WB_BYPASS, 1: 1 = register file is write-before-read, so the WB entry never causes a hazard.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1  in  5  ID source register 1.
- id_src2  in  5  ID source register 2.
- id_two_src  in  1  ID instruction reads id_src2.
- id_wb_en  in  1  ID instruction writes the register file.
- id_dest  in  5  ID destination register.
- id_mem_r_en  in  1  ID instruction is a load.
- id_br_taken  in  1  ID branch-resolution result.
- freeze  in  1  external memory wait; holds the whole pipeline.
- pc_write_en  out  1  PC register enable.
- ifid_write_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP controls into ID/EX.
- br_taken_out  out  1  gated branch-taken to the PC mux.
- stall_count  out  CNT_W  cycles with a hazard stall.
- flush_count  out  CNT_W  taken-branch flushes.

Behaviour:
- Scoreboard entry format: {v, wb, mr, dst[4:0]}. Entries are E (EXE), M (MEM) and W (WB).
- match(x) for a source s:
  - x.v & x.wb & (x.dst == s) & (s != 0);
  - the s2 term is qualified by id_two_src;
  - overall qualified by id_valid.
- Hazard when FWD_EN=1: match(E) & E.mr.
- Hazard when FWD_EN=0: match(E) | match(M) | (match(W) & ~WB_BYPASS).
- Combinational outputs when rst=0:
  - hazard = raw hazard & ~freeze.
  - pc_write_en = ifid_write_en = ~hazard & ~freeze.
  - idex_bubble = hazard.
  - br_taken_out = id_br_taken & id_valid & ~hazard & ~freeze. A branch whose operands are not ready is ignored until the stall clears.
  - ifid_flush = br_taken_out.
- Sequential update on clk:
  - rst=1: E, M, W cleared (v=0); both counters set to 0.
  - freeze=1: all scoreboard state and counters hold.
  - Otherwise W<=M and M<=E.
  - E <= hazard ? 0 : {id_valid, id_wb_en, id_mem_r_en, id_dest}. A bubble enters E as an invalid entry.
  - stall_count increments when hazard=1; flush_count increments when ifid_flush=1.
  - Both counters saturate at all-ones and never wrap.
- While rst=1, outputs are forced regardless of inputs: pc_write_en=1, ifid_write_en=1, ifid_flush=0, idex_bubble=0, br_taken_out=0.
- Reset mid-stall: the cycle after the reset edge has an empty scoreboard, so there is no stall.
- Latency: hazard decisions are same-cycle combinational from registered state; no output is registered except the counters.
- Register $0 as a destination never creates a hazard.
- Hazard and branch in the same cycle: the stall wins and the flush is suppressed.
- freeze and hazard in the same cycle: freeze wins; idex_bubble=0 and nothing advances.
- Stall lengths for a producer immediately followed by a dependent consumer:
  - FWD_EN=1 with a load producer: 1 cycle.
  - FWD_EN=0, WB_BYPASS=1: 2 cycles.
  - FWD_EN=0, WB_BYPASS=0: 3 cycles.

Test Plan:
- Load-use, FWD_EN=1:
  - Stimulus: lw $3 (id_mem_r_en=1, dest=3), then add with src1=3.
  - Required: exactly 1 cycle of pc_write_en=0 and idex_bubble=1; stall_count=1.
  - Same sequence with an ALU producer instead of the load: 0 stalls.
- RAW without forwarding, FWD_EN=0, WB_BYPASS=1:
  - Stimulus: add $5, then sub reading $5 on src2 with id_two_src=1.
  - Required: 2 stall cycles, stall_count=2.
  - Same sequence with id_two_src=0: 0 stalls.
- $0 destination: producer with dest=0 followed by a consumer reading src1=0 -> no stall in any parameter setting.
- Taken branch:
  - id_br_taken=1 with no hazard -> ifid_flush=1 and br_taken_out=1 for 1 cycle; flush_count=1.
  - Branch reading a register written by the preceding lw with FWD_EN=1 -> br_taken_out=0 during the stall cycle, then 1 in the following cycle.
- Freeze:
  - Assert freeze for 3 cycles during a pending stall -> scoreboard and counters unchanged, pc_write_en=0, idex_bubble=0.
  - After release, the stall resumes with its remaining length.
- Reset:
  - rst=1 in the middle of a 2-cycle stall (FWD_EN=0) -> next cycle has no stall and both counters read 0.
  - Drive 70000 stall cycles (CNT_W=16) -> stall_count holds at 16'hFFFF.
